riscv_fetch_queue: RTL and testbench

- Instruction-fetch front end placed directly upstream of the single-cycle RISC-V datapath.
- Owns the fetch PC and drives the address of the combinational instruction memory.
- Buffers fetched {pc, instruction} pairs in a small FIFO and hands them to the core over a valid/ready handshake.
- Accepts branch/jump redirects from the core and flushes stale entries.

---
 rtl/riscv_fetch_queue.sv | 169 ++++++++++++++++
 tb/tb_riscv_fetch_queue.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue
// -----------------------------------------------------------------------------
// Instruction-fetch front end for a single-cycle RISC-V core. Owns the fetch
// PC, addresses a combinational instruction memory, buffers {pc, instruction}
// pairs in a DEPTH-entry FIFO and presents the head to the core over a
// valid/ready handshake. A redirect from the core flushes the FIFO and reloads
// the fetch PC.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   imem_addr      instruction memory address (= fetch PC)
//   imem_rdata     instruction word, combinational from imem_addr
//   redirect_valid core requests a PC change (flush + reload)
//   redirect_pc    new fetch target
//   inst_valid     FIFO head is valid and not being flushed
//   inst_ready     core consumes the head this cycle
//   inst_out       head instruction
//   pc_out         head PC
//   pc4_out        head PC + 4 (mod 2^32)
//   fifo_count     occupancy, 0..DEPTH
//   fetch_misalign sticky misaligned-redirect flag (FETCH_ALIGN_CHECK_EN only)
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   When defined, redirect targets are forced word-aligned and a misaligned
//   target sets the sticky fetch_misalign output (cleared only by rst).
// -----------------------------------------------------------------------------
module riscv_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [31:0]       imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_out,
    output logic [31:0]       pc_out,
    output logic [31:0]       pc4_out,
    output logic [PTR_W:0]    fifo_count
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic              fetch_misalign
`endif
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [31:0]      fetch_pc_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [31:0]      pc_mem_r   [DEPTH];
    logic [31:0]      inst_mem_r [DEPTH];

    logic [31:0]      fetch_pc_nxt_s;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [PTR_W:0]   count_nxt_s;
    logic [31:0]      redirect_target_s;
    logic             push_s;
    logic             pop_s;
    logic             valid_s;

`ifdef FETCH_ALIGN_CHECK_EN
    logic             misalign_r;
    logic             misalign_nxt_s;
`endif

    // Handshake qualifiers; flushed entries are masked while a redirect is up.
    always_comb begin
        valid_s = (count_r != (PTR_W+1)'(0)) & ~redirect_valid;
        pop_s   = valid_s & inst_ready;
        push_s  = ~redirect_valid & ((count_r < DEPTH_C) | pop_s);
    end

    // Redirect target, word-aligned when the alignment check is built in.
    always_comb begin
`ifdef FETCH_ALIGN_CHECK_EN
        redirect_target_s = {redirect_pc[31:2], 2'b00};
        misalign_nxt_s    = misalign_r | (redirect_valid & (redirect_pc[1:0] != 2'b00));
`else
        redirect_target_s = redirect_pc;
`endif
    end

    // Next-state computation for fetch PC, pointers and occupancy.
    always_comb begin
        fetch_pc_nxt_s = fetch_pc_r;
        wr_ptr_nxt_s   = wr_ptr_r;
        rd_ptr_nxt_s   = rd_ptr_r;
        count_nxt_s    = count_r;
        if (redirect_valid) begin
            fetch_pc_nxt_s = redirect_target_s;
            wr_ptr_nxt_s   = {PTR_W{1'b0}};
            rd_ptr_nxt_s   = {PTR_W{1'b0}};
            count_nxt_s    = {(PTR_W+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_nxt_s   = wr_ptr_r + PTR_W'(1);
                fetch_pc_nxt_s = fetch_pc_r + 32'd4;
            end else begin
                wr_ptr_nxt_s   = wr_ptr_r;
                fetch_pc_nxt_s = fetch_pc_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + (PTR_W+1)'(1);
                2'b01:   count_nxt_s = count_r - (PTR_W+1)'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {(PTR_W+1){1'b0}};
        end else begin
            fetch_pc_r <= fetch_pc_nxt_s;
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            count_r    <= count_nxt_s;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Sticky misaligned-redirect flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= misalign_nxt_s;
        end
    end

    assign fetch_misalign = misalign_r;
`endif

    // FIFO storage; no write happens in a reset cycle.
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
            inst_mem_r[wr_ptr_r] <= imem_rdata;
        end
    end

    // Output drive from the head entry and control state.
    always_comb begin
        imem_addr  = fetch_pc_r;
        inst_valid = valid_s;
        inst_out   = inst_mem_r[rd_ptr_r];
        pc_out     = pc_mem_r[rd_ptr_r];
        pc4_out    = pc_mem_r[rd_ptr_r] + 32'd4;
        fifo_count = count_r;
    end

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Directed testbench for riscv_fetch_queue. Inputs change and outputs are
// checked at the falling clock edge; the DUT registers on the rising edge.
module tb_riscv_fetch_queue;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [31:0] pc4_out;
    logic [2:0]  fifo_count;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    int checks_cnt = 0;
    int errors_cnt = 0;

    localparam logic [31:0] TAG = 32'hA5A5_0000;

    riscv_fetch_queue #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4),
        .PTR_W    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .pc_out         (pc_out),
        .pc4_out        (pc4_out),
        .fifo_count     (fifo_count)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    // Clock generation, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory model.
    always_comb imem_rdata = imem_addr ^ TAG;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
        chk({tag, "_pc"}, pc_out, pc);
        chk({tag, "_inst"}, inst_out, pc ^ TAG);
        chk({tag, "_pc4"}, pc4_out, pc + 32'd4);
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        inst_ready     = 1'b1;
        step();
        step();
        // Reset state
        chk("rst_count", {29'd0, fifo_count}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0000_0000);

        // Free run with ready=1: one-cycle latency, then sequential PCs
        rst = 1'b0;
        #1;
        chk("empty_valid", {31'd0, inst_valid}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk_head("run", 32'(k * 4));
            chk("run_count", {29'd0, fifo_count}, 32'd1);
            chk("run_addr", imem_addr, 32'(k * 4 + 4));
        end

        // Stall: fill to DEPTH and hold the fetch address
        rst = 1'b1;
        inst_ready = 1'b0;
        step();
        chk("rst2_count", {29'd0, fifo_count}, 32'd0);
        chk("rst2_addr", imem_addr, 32'h0000_0000);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) step();
        chk("stall_count", {29'd0, fifo_count}, 32'd4);
        chk("stall_addr", imem_addr, 32'h0000_0010);
        chk_head("stall_head", 32'h0000_0000);

        // Release: full FIFO pops and pushes together, order kept across wrap
        inst_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            chk_head("drain", 32'(k * 4));
            chk("drain_count", {29'd0, fifo_count}, 32'd4);
            step();
        end

        // Redirect with 3 entries queued
        rst = 1'b1;
        inst_ready = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();
        step();
        chk("pre_redir_count", {29'd0, fifo_count}, 32'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        inst_ready     = 1'b1;
        #1;
        chk("redir_valid_mask", {31'd0, inst_valid}, 32'd0);
        step();
        chk("redir_count", {29'd0, fifo_count}, 32'd0);
        chk("redir_addr", imem_addr, 32'h0000_0200);
        redirect_valid = 1'b0;
        #1;
        chk("redir_empty_valid", {31'd0, inst_valid}, 32'd0);
        step();
        chk_head("redir_head", 32'h0000_0200);

        // Back-to-back redirects: the last one wins
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        step();
        redirect_pc    = 32'h0000_0400;
        step();
        chk("b2b_addr", imem_addr, 32'h0000_0400);
        chk("b2b_count", {29'd0, fifo_count}, 32'd0);
        redirect_valid = 1'b0;
        step();
        chk_head("b2b_head", 32'h0000_0400);

        // Fetch PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        chk_head("wrap_head", 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        step();
        chk_head("wrap_next", 32'h0000_0000);

        // Reset with 2 entries queued and a redirect pending
        inst_ready = 1'b0;
        step();
        chk("pre_rst_count", {29'd0, fifo_count}, 32'd2);
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0800;
        step();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("rst3_count", {29'd0, fifo_count}, 32'd0);
        chk("rst3_addr", imem_addr, 32'h0000_0000);
        chk("rst3_valid", {31'd0, inst_valid}, 32'd0);
        step();
        chk_head("rst3_head", 32'h0000_0000);

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned redirect: aligned fetch, sticky flag until reset
        chk("mis_init", {31'd0, fetch_misalign}, 32'd0);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
        chk("mis_addr", imem_addr, 32'h0000_0100);
        chk("mis_flag", {31'd0, fetch_misalign}, 32'd1);
        step();
        chk_head("mis_head", 32'h0000_0100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        chk("mis_sticky", {31'd0, fetch_misalign}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mis_clear", {31'd0, fetch_misalign}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
